// File: rtl/ddr3_cmd_arb_pkg.sv
// Shared DDR3 command encodings ({ras_n, cas_n, we_n}) and arbiter constants.
package ddr3_cmd_arb_pkg;

  localparam logic [2:0] CMD_MRS   = 3'b000;
  localparam logic [2:0] CMD_REFR  = 3'b001;
  localparam logic [2:0] CMD_PREC  = 3'b010;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_ZQCL  = 3'b110;
  localparam logic [2:0] CMD_NOOP  = 3'b111;

  // Address bit that selects "all banks" on a precharge.
  localparam int unsigned AP_BIT = 10;

  // Width of the postponed-refresh counter (holds up to 8).
  localparam int unsigned REF_CTR_W = 4;

endpackage

// File: rtl/ddr3_ref_ctr.sv
// Postponed-refresh counter: saturating increment, decrement per issued REFRESH.
module ddr3_ref_ctr
  import ddr3_cmd_arb_pkg::*;
#(
  parameter int unsigned REF_MAX = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 dec,
  output logic [REF_CTR_W-1:0] count,
  output logic                 full
);

  logic [REF_CTR_W-1:0] count_d;

  // Next count; a coincident inc and dec cancel out.
  always_comb begin
    count_d = count;
    if (inc && !dec && (count != REF_CTR_W'(REF_MAX))) begin
      count_d = count + REF_CTR_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count_d = count - REF_CTR_W'(1);
    end
  end

  // Count register and registered full flag tracking the new count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      full  <= 1'b0;
    end else begin
      count <= count_d;
      full  <= (count_d == REF_CTR_W'(REF_MAX));
    end
  end

endmodule

// File: rtl/ddr3_cmd_arb.sv
// DDR3 command arbiter: init channel until run, then controller commands with
// refresh bursts (PREA + N x REFR) inserted between controller transactions.
module ddr3_cmd_arb
  import ddr3_cmd_arb_pkg::*;
#(
  parameter int unsigned DDR_ROW_BITS = 13,
  parameter int unsigned REF_MAX      = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cfg_run_i,
  input  logic                    cfg_ref_i,
  input  logic                    cfg_req_i,
  output logic                    cfg_rdy_o,
  input  logic [2:0]              cfg_cmd_i,
  input  logic [2:0]              cfg_ba_i,
  input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
  input  logic                    fsm_req_i,
  output logic                    fsm_rdy_o,
  input  logic [2:0]              fsm_cmd_i,
  input  logic [2:0]              fsm_ba_i,
  input  logic [DDR_ROW_BITS-1:0] fsm_adr_i,
  output logic                    fsm_gnt_o,
  output logic                    ref_urg_o,
  output logic                    ctl_req_o,
  input  logic                    ctl_rdy_i,
  output logic [2:0]              ctl_cmd_o,
  output logic [2:0]              ctl_ba_o,
  output logic [DDR_ROW_BITS-1:0] ctl_adr_o
);

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_FSM, ST_PREA, ST_REFR} state_t;

  localparam logic [DDR_ROW_BITS-1:0] PREC_ADR = DDR_ROW_BITS'(1) << AP_BIT;

  state_t                  state_q, state_d;
  logic                    req_q, req_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [2:0]              ba_q, ba_d;
  logic [DDR_ROW_BITS-1:0] adr_q, adr_d;

  logic [REF_CTR_W-1:0] pending;
  logic                 ref_inc;
  logic                 ref_dec;

  // Refresh-due pulses only count once the device is initialised.
  assign ref_inc = cfg_ref_i & cfg_run_i;
  assign ref_dec = (state_q == ST_REFR) & req_q & ctl_rdy_i;

  ddr3_ref_ctr #(
    .REF_MAX (REF_MAX)
  ) u_ref_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (ref_inc),
    .dec     (ref_dec),
    .count   (pending),
    .full    (ref_urg_o)
  );

  // State and registered refresh-command outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      req_q   <= 1'b0;
      cmd_q   <= CMD_NOOP;
      ba_q    <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      adr_q   <= adr_d;
    end
  end

  // Next-state logic; refresh commands are loaded one cycle ahead so they come from flops.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cmd_d   = cmd_q;
    ba_d    = ba_q;
    adr_d   = adr_q;
    unique case (state_q)
      ST_INIT: begin
        if (cfg_run_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // Refresh beats a same-cycle controller request.
        if (pending != '0) begin
          state_d = ST_PREA;
          req_d   = 1'b1;
          cmd_d   = CMD_PREC;
          ba_d    = '0;
          adr_d   = PREC_ADR;
        end else if (fsm_req_i) begin
          state_d = ST_FSM;
        end
      end
      ST_FSM: begin
        if (!fsm_req_i) state_d = ST_IDLE;
      end
      ST_PREA: begin
        if (ctl_rdy_i) begin
          state_d = ST_REFR;
          cmd_d   = CMD_REFR;
          adr_d   = '0;
        end
      end
      ST_REFR: begin
        // Stay for another REFR while the post-transfer count is non-zero.
        if (ctl_rdy_i && !((pending > 4'd1) || ref_inc)) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          cmd_d   = CMD_NOOP;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Output steering: init and controller channels pass through, else registers.
  always_comb begin
    ctl_req_o = req_q;
    ctl_cmd_o = cmd_q;
    ctl_ba_o  = ba_q;
    ctl_adr_o = adr_q;
    cfg_rdy_o = 1'b0;
    fsm_rdy_o = 1'b0;
    fsm_gnt_o = 1'b0;
    if (state_q == ST_INIT) begin
      ctl_req_o = cfg_req_i;
      ctl_cmd_o = cfg_cmd_i;
      ctl_ba_o  = cfg_ba_i;
      ctl_adr_o = cfg_adr_i;
      cfg_rdy_o = ctl_rdy_i;
    end else if (state_q == ST_FSM) begin
      ctl_req_o = fsm_req_i;
      ctl_cmd_o = fsm_cmd_i;
      ctl_ba_o  = fsm_ba_i;
      ctl_adr_o = fsm_adr_i;
      fsm_rdy_o = ctl_rdy_i;
      fsm_gnt_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_arb.sv
// Self-checking bench for ddr3_cmd_arb: random ready/commands, queue-based expected streams.
module tb_ddr3_cmd_arb;
  import ddr3_cmd_arb_pkg::*;

  localparam int RB      = 13;
  localparam int REF_MAX = 8;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [2:0]    ba;
    logic [RB-1:0] adr;
  } cmd_t;

  logic          clock, reset_n;
  logic          cfg_run_i, cfg_ref_i, cfg_req_i, cfg_rdy_o;
  logic [2:0]    cfg_cmd_i, cfg_ba_i;
  logic [RB-1:0] cfg_adr_i;
  logic          fsm_req_i, fsm_rdy_o, fsm_gnt_o, ref_urg_o;
  logic [2:0]    fsm_cmd_i, fsm_ba_i;
  logic [RB-1:0] fsm_adr_i;
  logic          ctl_req_o, ctl_rdy_i;
  logic [2:0]    ctl_cmd_o, ctl_ba_o;
  logic [RB-1:0] ctl_adr_o;

  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 1;  // 0 low, 1 high, 2 random, 3 driven by the test
  int   fsm_rdy_seen = 0;
  cmd_t mon_q[$];
  cmd_t exp_q[$];
  logic [RB-1:0] pa_adr;

  ddr3_cmd_arb #(
    .DDR_ROW_BITS (RB),
    .REF_MAX      (REF_MAX)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg_run_i (cfg_run_i),
    .cfg_ref_i (cfg_ref_i),
    .cfg_req_i (cfg_req_i),
    .cfg_rdy_o (cfg_rdy_o),
    .cfg_cmd_i (cfg_cmd_i),
    .cfg_ba_i  (cfg_ba_i),
    .cfg_adr_i (cfg_adr_i),
    .fsm_req_i (fsm_req_i),
    .fsm_rdy_o (fsm_rdy_o),
    .fsm_cmd_i (fsm_cmd_i),
    .fsm_ba_i  (fsm_ba_i),
    .fsm_adr_i (fsm_adr_i),
    .fsm_gnt_o (fsm_gnt_o),
    .ref_urg_o (ref_urg_o),
    .ctl_req_o (ctl_req_o),
    .ctl_rdy_i (ctl_rdy_i),
    .ctl_cmd_o (ctl_cmd_o),
    .ctl_ba_o  (ctl_ba_o),
    .ctl_adr_o (ctl_adr_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Downstream ready generator.
  initial begin
    ctl_rdy_i = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rdy_mode == 0) ctl_rdy_i = 1'b0;
      else if (rdy_mode == 1) ctl_rdy_i = 1'b1;
      else if (rdy_mode == 2) ctl_rdy_i = 1'($urandom_range(0, 1));
    end
  end

  // Record every transferred command.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && ctl_req_o === 1'b1 && ctl_rdy_i === 1'b1)
        mon_q.push_back({ctl_cmd_o, ctl_ba_o, ctl_adr_o});
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_rdy(input int mode);
    @(negedge clock);
    rdy_mode = mode;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_mon(input int n, input int budget);
    for (int c = 0; c < budget && mon_q.size() < n; c++) @(posedge clock);
    #1;
  endtask

  task automatic cfg_send(input logic [2:0] cmd, input logic [2:0] ba,
                          input logic [RB-1:0] adr, output bit done);
    done = 1'b0;
    cfg_req_i = 1'b1; cfg_cmd_i = cmd; cfg_ba_i = ba; cfg_adr_i = adr;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (fsm_rdy_o !== 1'b0) fsm_rdy_seen++;
      if (cfg_rdy_o === 1'b1) done = 1'b1;
      @(posedge clock);
      #1;
    end
    cfg_req_i = 1'b0; cfg_cmd_i = CMD_NOOP; cfg_ba_i = '0; cfg_adr_i = '0;
  endtask

  task automatic test_reset();
    logic [RB-1:0] r;
    reset_n = 1'b0;
    cfg_run_i = 0; cfg_ref_i = 0; cfg_req_i = 0; cfg_cmd_i = CMD_NOOP; cfg_ba_i = 0; cfg_adr_i = 0;
    fsm_req_i = 0; fsm_cmd_i = CMD_NOOP; fsm_ba_i = 0; fsm_adr_i = 0;
    rdy_mode = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (ctl_req_o !== 1'b0) begin errors++; $display("FAIL reset_ctl_req actual=%b required=0", ctl_req_o); end
    checks++; if (fsm_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_fsm_gnt actual=%b required=0", fsm_gnt_o); end
    checks++; if (ref_urg_o !== 1'b0) begin errors++; $display("FAIL reset_ref_urg actual=%b required=0", ref_urg_o); end
    checks++; if (fsm_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_fsm_rdy actual=%b required=0", fsm_rdy_o); end
    r = RB'($urandom);
    cfg_cmd_i = CMD_MRS; cfg_ba_i = 3'd5; cfg_adr_i = r;
    #1;
    checks++; if ({ctl_cmd_o, ctl_ba_o, ctl_adr_o} !== {CMD_MRS, 3'd5, r}) begin
      errors++; $display("FAIL init_mirror actual=%h required=%h", {ctl_cmd_o, ctl_ba_o, ctl_adr_o}, {CMD_MRS, 3'd5, r});
    end
    checks++; if (cfg_rdy_o !== 1'b1) begin errors++; $display("FAIL init_cfg_rdy actual=%b required=1", cfg_rdy_o); end
    cfg_cmd_i = CMD_NOOP; cfg_ba_i = 0; cfg_adr_i = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_init();
    cmd_t e;
    cmd_t got;
    bit done;
    int to = 0;
    logic [2:0] mr_ba [4];
    mr_ba[0] = 3'd2; mr_ba[1] = 3'd3; mr_ba[2] = 3'd1; mr_ba[3] = 3'd0;
    mon_q.delete(); exp_q.delete(); fsm_rdy_seen = 0;
    set_rdy(2);
    for (int i = 0; i < 4; i++) begin
      e = {CMD_MRS, mr_ba[i], RB'($urandom)};
      exp_q.push_back(e);
    end
    exp_q.push_back({CMD_ZQCL, 3'd0, pa_adr});
    for (int i = 0; i < 5; i++) begin
      cfg_send(exp_q[i].cmd, exp_q[i].ba, exp_q[i].adr, done);
      if (!done) to++;
    end
    checks++; if (to !== 0) begin errors++; $display("FAIL init_timeout actual=%0d required=0", to); end
    checks++; if (mon_q.size() !== 5) begin errors++; $display("FAIL init_count actual=%0d required=5", mon_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < mon_q.size()) got = mon_q[i];
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL init_seq[%0d] actual=%h required=%h", i, got, exp_q[i]); end
    end
    checks++; if (fsm_rdy_seen !== 0) begin errors++; $display("FAIL init_fsm_rdy actual=%0d required=0", fsm_rdy_seen); end
    cfg_run_i = 1'b1;
    set_rdy(1);
    cycles(2);
    @(negedge clock);
    checks++; if (cfg_rdy_o !== 1'b0) begin errors++; $display("FAIL idle_cfg_rdy actual=%b required=0", cfg_rdy_o); end
    checks++; if ({ctl_req_o, ctl_cmd_o} !== {1'b0, CMD_NOOP}) begin
      errors++; $display("FAIL idle_outputs actual=%b required=%b", {ctl_req_o, ctl_cmd_o}, {1'b0, CMD_NOOP});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_single_refresh();
    logic r0, r1, r2;
    logic [2:0] c2;
    logic [RB-1:0] a2;
    cmd_t got;
    set_rdy(2);
    mon_q.delete(); exp_q.delete();
    cfg_ref_i = 1'b1;
    @(negedge clock); r0 = ctl_req_o;
    @(posedge clock); #1; cfg_ref_i = 1'b0;
    @(negedge clock); r1 = ctl_req_o;
    @(negedge clock); r2 = ctl_req_o; c2 = ctl_cmd_o; a2 = ctl_adr_o;
    @(posedge clock); #1;
    exp_q.push_back({CMD_PREC, 3'd0, pa_adr});
    exp_q.push_back({CMD_REFR, 3'd0, {RB{1'b0}}});
    wait_mon(2, 200);
    cycles(5);
    checks++; if ({r0, r1, r2} !== 3'b001) begin errors++; $display("FAIL ref_latency actual=%b required=001", {r0, r1, r2}); end
    checks++; if ({c2, a2} !== {CMD_PREC, pa_adr}) begin errors++; $display("FAIL ref_first_prec actual=%h required=%h", {c2, a2}, {CMD_PREC, pa_adr}); end
    checks++; if (mon_q.size() !== 2) begin errors++; $display("FAIL ref_count actual=%0d required=2", mon_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < mon_q.size()) got = mon_q[i];
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL ref_seq[%0d] actual=%h required=%h", i, got, exp_q[i]); end
    end
    checks++; if (ref_urg_o !== 1'b0) begin errors++; $display("FAIL ref_urg_single actual=%b required=0", ref_urg_o); end
  endtask

  task automatic test_deferral();
    cmd_t tx [6];
    cmd_t e, got;
    int idx = 0, cyc = 0, drop = 0;
    logic g0, g1, q1, xfer;
    mon_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0: e.cmd = CMD_ACT;
        1: e.cmd = CMD_READ;
        default: e.cmd = CMD_WRITE;
      endcase
      e.ba = 3'($urandom); e.adr = RB'($urandom);
      tx[i] = e; exp_q.push_back(e);
    end
    exp_q.push_back({CMD_PREC, 3'd0, pa_adr});
    for (int i = 0; i < 3; i++) exp_q.push_back({CMD_REFR, 3'd0, {RB{1'b0}}});
    fsm_req_i = 1'b1;
    {fsm_cmd_i, fsm_ba_i, fsm_adr_i} = tx[0];
    g0 = 1'bx; g1 = 1'bx; q1 = 1'bx;
    while (idx < 6 && cyc < 400) begin
      @(negedge clock);
      if (cyc == 0) g0 = fsm_gnt_o;
      if (cyc == 1) begin g1 = fsm_gnt_o; q1 = ctl_req_o; end
      if (cyc >= 1 && fsm_gnt_o !== 1'b1) drop++;
      xfer = (fsm_rdy_o === 1'b1) && (ctl_req_o === 1'b1);
      @(posedge clock); #1;
      cyc++;
      cfg_ref_i = (cyc == 1 || cyc == 3 || cyc == 5);
      if (xfer) begin
        idx++;
        if (idx < 6) {fsm_cmd_i, fsm_ba_i, fsm_adr_i} = tx[idx];
      end
    end
    fsm_req_i = 1'b0; cfg_ref_i = 1'b0; fsm_cmd_i = CMD_NOOP;
    wait_mon(10, 500);
    cycles(5);
    checks++; if (idx !== 6) begin errors++; $display("FAIL defer_sent actual=%0d required=6", idx); end
    checks++; if ({g0, g1, q1} !== 3'b011) begin errors++; $display("FAIL fsm_latency actual=%b required=011", {g0, g1, q1}); end
    checks++; if (drop !== 0) begin errors++; $display("FAIL defer_gnt_held actual=%0d required=0", drop); end
    checks++; if (mon_q.size() !== 10) begin errors++; $display("FAIL defer_count actual=%0d required=10", mon_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < mon_q.size()) got = mon_q[i];
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL defer_seq[%0d] actual=%h required=%h", i, got, exp_q[i]); end
    end
    checks++; if (fsm_gnt_o !== 1'b0) begin errors++; $display("FAIL defer_gnt_release actual=%b required=0", fsm_gnt_o); end
  endtask

  task automatic test_saturation();
    int model = 0;
    cmd_t got;
    mon_q.delete(); exp_q.delete();
    set_rdy(0);
    fsm_req_i = 1'b1; fsm_cmd_i = CMD_ACT; fsm_ba_i = 3'd1; fsm_adr_i = RB'(5);
    for (int k = 0; k < 10; k++) begin
      cfg_ref_i = 1'b1;
      @(posedge clock); #1;
      cfg_ref_i = 1'b0;
      model = (model < REF_MAX) ? model + 1 : model;
      @(negedge clock);
      checks++; if (ref_urg_o !== (model == REF_MAX)) begin
        errors++; $display("FAIL sat_urg[%0d] actual=%b required=%b", k, ref_urg_o, (model == REF_MAX));
      end
      @(posedge clock); #1;
    end
    checks++; if (fsm_gnt_o !== 1'b1) begin errors++; $display("FAIL sat_gnt_held actual=%b required=1", fsm_gnt_o); end
    fsm_req_i = 1'b0; fsm_cmd_i = CMD_NOOP;
    exp_q.push_back({CMD_PREC, 3'd0, pa_adr});
    for (int i = 0; i < model; i++) exp_q.push_back({CMD_REFR, 3'd0, {RB{1'b0}}});
    set_rdy(2);
    wait_mon(model + 1, 800);
    cycles(8);
    checks++; if (mon_q.size() !== model + 1) begin errors++; $display("FAIL sat_count actual=%0d required=%0d", mon_q.size(), model + 1); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < mon_q.size()) got = mon_q[i];
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL sat_seq[%0d] actual=%h required=%h", i, got, exp_q[i]); end
    end
    checks++; if (ref_urg_o !== 1'b0) begin errors++; $display("FAIL sat_urg_clear actual=%b required=0", ref_urg_o); end
  endtask

  task automatic test_simultaneous();
    bit found = 0;
    logic [3:0] cnt;
    int mid;
    cmd_t got;
    mon_q.delete(); exp_q.delete();
    set_rdy(3);
    ctl_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cfg_ref_i = 1'b1;
      @(posedge clock); #1;
      cfg_ref_i = 1'b0;
      @(posedge clock); #1;
    end
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clock);
      if (ctl_req_o === 1'b1 && ctl_cmd_o === CMD_PREC) found = 1;
    end
    @(posedge clock); #1; ctl_rdy_i = 1'b1;                   // PREC
    @(posedge clock); #1;                                     // first REFR, 3 -> 2
    @(posedge clock); #1; ctl_rdy_i = 1'b0;
    @(posedge clock); #1; ctl_rdy_i = 1'b1; cfg_ref_i = 1'b1; // REFR coincident with due pulse
    @(posedge clock); #1; ctl_rdy_i = 1'b0; cfg_ref_i = 1'b0;
    @(negedge clock);
    cnt = dut.u_ref_ctr.count;
    mid = mon_q.size();
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL sim_prec_seen actual=%b required=1", found); end
    checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL sim_pending actual=%0d required=2", cnt); end
    checks++; if (mid !== 3) begin errors++; $display("FAIL sim_mid_count actual=%0d required=3", mid); end
    exp_q.push_back({CMD_PREC, 3'd0, pa_adr});
    for (int i = 0; i < 4; i++) exp_q.push_back({CMD_REFR, 3'd0, {RB{1'b0}}});
    set_rdy(2);
    wait_mon(5, 300);
    cycles(8);
    checks++; if (mon_q.size() !== 5) begin errors++; $display("FAIL sim_total actual=%0d required=5", mon_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < mon_q.size()) got = mon_q[i];
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL sim_seq[%0d] actual=%h required=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_run_low_ignored();
    bit got = 0;
    cmd_t e;
    mon_q.delete();
    set_rdy(1);
    cfg_run_i = 1'b0;
    cfg_req_i = 1'b1; cfg_cmd_i = CMD_MRS; cfg_ba_i = 3'd1; cfg_adr_i = RB'(7);
    cfg_ref_i = 1'b1;
    @(posedge clock); #1;
    cfg_ref_i = 1'b0;
    cycles(8);
    checks++; if (mon_q.size() !== 0) begin errors++; $display("FAIL runlow_quiet actual=%0d required=0", mon_q.size()); end
    @(negedge clock);
    checks++; if (cfg_rdy_o !== 1'b0) begin errors++; $display("FAIL runlow_cfg_rdy actual=%b required=0", cfg_rdy_o); end
    @(posedge clock); #1;
    e = {CMD_READ, 3'd4, RB'(12'h123)};
    fsm_req_i = 1'b1; {fsm_cmd_i, fsm_ba_i, fsm_adr_i} = e;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (fsm_rdy_o === 1'b1 && fsm_gnt_o === 1'b1) got = 1;
      @(posedge clock); #1;
    end
    fsm_req_i = 1'b0; fsm_cmd_i = CMD_NOOP;
    cycles(3);
    checks++; if (mon_q.size() !== 1) begin errors++; $display("FAIL runlow_fsm_count actual=%0d required=1", mon_q.size()); end
    if (mon_q.size() > 0) begin
      checks++; if (mon_q[0] !== e) begin errors++; $display("FAIL runlow_fsm_cmd actual=%h required=%h", mon_q[0], e); end
    end
    cfg_req_i = 1'b0; cfg_cmd_i = CMD_NOOP; cfg_ba_i = '0; cfg_adr_i = '0;
    cfg_run_i = 1'b1;
  endtask

  task automatic test_reset_mid_prec();
    bit found = 0;
    bit done;
    cmd_t e;
    mon_q.delete();
    set_rdy(0);
    cfg_ref_i = 1'b1;
    @(posedge clock); #1;
    cfg_ref_i = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clock);
      if (ctl_req_o === 1'b1 && ctl_cmd_o === CMD_PREC) found = 1;
    end
    #2;
    reset_n = 1'b0; cfg_run_i = 1'b0;
    #1;
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_prec_seen actual=%b required=1", found); end
    checks++; if (ctl_req_o !== 1'b0) begin errors++; $display("FAIL rst_async_req actual=%b required=0", ctl_req_o); end
    checks++; if (ctl_cmd_o !== CMD_NOOP) begin errors++; $display("FAIL rst_async_cmd actual=%b required=%b", ctl_cmd_o, CMD_NOOP); end
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    set_rdy(1);
    cycles(10);
    checks++; if (mon_q.size() !== 0) begin errors++; $display("FAIL rst_no_reissue actual=%0d required=0", mon_q.size()); end
    e = {CMD_MRS, 3'd0, RB'(12'h0a5)};
    cfg_send(e.cmd, e.ba, e.adr, done);
    cycles(2);
    checks++; if (mon_q.size() !== 1) begin errors++; $display("FAIL rst_cfg_count actual=%0d required=1", mon_q.size()); end
    if (mon_q.size() > 0) begin
      checks++; if (mon_q[0] !== e) begin errors++; $display("FAIL rst_cfg_cmd actual=%h required=%h", mon_q[0], e); end
    end
    cfg_run_i = 1'b1;
    cycles(10);
    checks++; if (mon_q.size() !== 1) begin errors++; $display("FAIL rst_after_run actual=%0d required=1", mon_q.size()); end
  endtask

  initial begin
    pa_adr = RB'(1) << 10;
    test_reset();
    test_init();
    test_single_refresh();
    test_deferral();
    test_saturation();
    test_simultaneous();
    test_run_low_ignored();
    test_reset_mid_prec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_cmd_arb.md
DDR3_CMD_ARB -- requirements
Module: ddr3_cmd_arb

Interface
REQ-001 SHALL have parameter DDR_ROW_BITS, default 13, row/address width.
REQ-002 SHALL have parameter REF_MAX, default 8, maximum postponed REFRESH count (1..8).
REQ-003 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports cfg_run_i (in, 1) and cfg_ref_i (in, 1): init-done level and one-cycle refresh-due pulse, both from ddr3_cfg.
REQ-006 SHALL have ports cfg_req_i (in, 1), cfg_rdy_o (out, 1), cfg_cmd_i (in, 3), cfg_ba_i (in, 3), cfg_adr_i (in, DDR_ROW_BITS): init command channel.
REQ-007 SHALL have ports fsm_req_i (in, 1), fsm_rdy_o (out, 1), fsm_cmd_i (in, 3), fsm_ba_i (in, 3), fsm_adr_i (in, DDR_ROW_BITS): memory-controller command channel.
REQ-008 SHALL have port fsm_gnt_o (out, 1), channel owned by controller; ref_urg_o (out, 1), pending count equals REF_MAX.
REQ-009 SHALL have ports ctl_req_o (out, 1), ctl_rdy_i (in, 1), ctl_cmd_o (out, 3), ctl_ba_o (out, 3), ctl_adr_o (out, DDR_ROW_BITS): to ddr3_ddl.

Function
REQ-010 A command SHALL transfer on a cycle with ctl_req_o && ctl_rdy_i; every source SHALL hold req/cmd/ba/adr stable until it transfers.
REQ-011 States SHALL be ST_INIT, ST_IDLE, ST_FSM, ST_PREA, ST_REFR.
REQ-012 ST_INIT: ctl_* SHALL mirror cfg_* combinationally, cfg_rdy_o = ctl_rdy_i; fsm_rdy_o = 0; exit to ST_IDLE on the first cycle cfg_run_i = 1.
REQ-013 ST_IDLE: pending > 0 SHALL go to ST_PREA (refresh wins over a same-cycle fsm_req_i); else fsm_req_i = 1 SHALL go to ST_FSM; ctl_req_o = 0, ctl_cmd_o = CMD_NOOP.
REQ-014 ST_FSM: fsm_gnt_o = 1; ctl_* SHALL mirror fsm_* combinationally, fsm_rdy_o = ctl_rdy_i; the grant SHALL be held until fsm_req_i is sampled 0, then return to ST_IDLE (multi-command transactions not interrupted).
REQ-015 ST_PREA SHALL issue CMD_PREC with ctl_adr_o[10] = 1, all other address bits and ba = 0, from registered outputs asserted the cycle after entry; on transfer go to ST_REFR.
REQ-016 ST_REFR SHALL issue CMD_REFR (ba, adr = 0) from registers; on transfer decrement pending; if pending after decrement > 0, issue a further CMD_REFR without another precharge, else return to ST_IDLE.
REQ-017 Pending counter SHALL be 4 bits, increment on cfg_ref_i only when cfg_run_i = 1, saturate at REF_MAX (extra pulses dropped); simultaneous increment and REFR transfer SHALL leave it unchanged.
REQ-018 ref_urg_o SHALL be registered, high whenever pending = REF_MAX; the controller is required to release fsm_req_i when urgent.
REQ-019 cfg_run_i falling in any state other than ST_INIT SHALL be ignored.
REQ-020 Outside ST_INIT cfg_rdy_o SHALL be 0; outside ST_FSM fsm_rdy_o and fsm_gnt_o SHALL be 0.
REQ-021 Latency: ST_IDLE to first fsm command on ctl_req_o SHALL be 1 cycle; refresh-due in ST_IDLE to CMD_PREC on ctl_req_o SHALL be 2 cycles.

Reset
REQ-022 reset_n low SHALL asynchronously force ST_INIT, pending = 0, ref_urg_o = 0, fsm_gnt_o = 0, registered ctl_req_o = 0, ctl_cmd_o register = CMD_NOOP, ba/adr registers = 0.
REQ-023 Reset asserted mid-command SHALL abandon it; no command SHALL be reissued after release.

Structure
REQ-024 CMD_NOOP, CMD_PREC, CMD_REFR and other 3-bit {ras_n,cas_n,we_n} encodings SHALL come from the shared ddr3_settings.vh; state encodings stay local.
REQ-025 The refresh pending counter SHALL be a sub-module ddr3_ref_ctr (inc, dec, count, full); no other sub-modules.

Verification
REQ-026 Init: cfg issues 4 MRS + ZQCL with ctl_rdy_i random -> identical sequence on ctl_*, fsm_rdy_o = 0 throughout.
REQ-027 Single refresh: cfg_ref_i pulse in ST_IDLE -> PREC (adr = 0x400) then one REFR, pending 1 -> 0, back to ST_IDLE.
REQ-028 Deferral: fsm holds 6-command transaction, 3 cfg_ref_i pulses during it -> all 6 commands uninterrupted, then PREC + 3 REFR.
REQ-029 Saturation: 10 pulses with fsm_req_i held -> pending = 8, ref_urg_o = 1; after release exactly 8 REFR issued.
REQ-030 Simultaneous: cfg_ref_i coincident with REFR transfer at pending = 2 -> pending stays 2.
REQ-031 Async reset mid-PREC with ctl_rdy_i = 0 -> ctl_req_o = 0 immediately, ST_INIT, no commands until cfg_req_i.
